// File: rtl/ibus_dbus_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Module      : ibus_dbus_arbiter_pkg
// Description : Avalon-MM request/response types and arbiter FSM encoding.
// Revision    : 1.0 - initial release
// =============================================================================
package ibus_dbus_arbiter_pkg;

  localparam int AVL_ADDR_W = 32;
  localparam int AVL_DATA_W = 32;
  localparam int ARB_CNT_W  = 4;

  typedef struct packed {
    logic                      read;
    logic                      write;
    logic [AVL_ADDR_W-1:0]     address;
    logic [AVL_DATA_W-1:0]     writedata;
    logic [AVL_DATA_W/8-1:0]   byteenable;
  } avalon_req_t;

  typedef struct packed {
    logic [AVL_DATA_W-1:0]     readdata;
    logic                      waitrequest;
    logic                      readdatavalid;
  } avalon_resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD_I = 3'd1,
    CMD_D = 3'd2,
    RSP_I = 3'd3,
    RSP_D = 3'd4
  } arb_state_e;

  function automatic logic req_active(input avalon_req_t req);
    return req.read | req.write;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibus_dbus_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : ibus_dbus_arbiter_if
// Description : One Avalon-MM link (request + response) with master/slave views.
// Revision    : 1.0 - initial release
// =============================================================================
interface ibus_dbus_arbiter_if;
  import ibus_dbus_arbiter_pkg::*;

  avalon_req_t  avalon_req;
  avalon_resp_t avalon_resp;

  modport master (output avalon_req, input avalon_resp);
  modport slave  (input avalon_req, output avalon_resp);

endinterface
`default_nettype wire

// File: rtl/ibus_dbus_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : ibus_dbus_arbiter
// Description : Shares one Avalon-MM port between ibus and dbus, one access
//               outstanding at a time, with an ibus anti-starvation guard.
// Revision    : 1.0 - initial release
// =============================================================================
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = AVL_ADDR_W,
  parameter int DATA_W      = AVL_DATA_W,
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_WAIT    = 4
) (
  input wire                   clk,
  input wire                   rst,
  ibus_dbus_arbiter_if.slave   ibus,
  ibus_dbus_arbiter_if.slave   dbus,
  ibus_dbus_arbiter_if.master  mem
);

  localparam logic [ARB_CNT_W-1:0] c_max_wait = ARB_CNT_W'(MAX_WAIT);

  arb_state_e           r_state;
  logic [ARB_CNT_W-1:0] r_starve_cnt;
  logic                 r_rr_ptr;      // 1: ibus wins the next contention

  logic         w_i_act;
  logic         w_d_act;
  logic         w_prio_i;
  logic         w_grant_i;
  logic         w_grant_d;
  logic         w_own_i;
  logic         w_cmd_phase;
  logic         w_rsp_phase;
  logic         w_owner_act;
  avalon_req_t  w_sel_req;
  avalon_req_t  w_mem_req;
  avalon_resp_t w_iresp;
  avalon_resp_t w_dresp;

  always_comb begin
    w_i_act = req_active(ibus.avalon_req);
    w_d_act = req_active(dbus.avalon_req);

    if (ROUND_ROBIN != 0) begin
      w_prio_i = r_rr_ptr;
    end else begin
      w_prio_i = (r_starve_cnt == c_max_wait);
    end

    w_grant_i   = (r_state == IDLE) && w_i_act && (!w_d_act || w_prio_i);
    w_grant_d   = (r_state == IDLE) && w_d_act && !w_grant_i;
    w_own_i     = w_grant_i || (r_state == CMD_I) || (r_state == RSP_I);
    w_cmd_phase = w_grant_i || w_grant_d || (r_state == CMD_I) || (r_state == CMD_D);
    w_rsp_phase = (r_state == RSP_I) || (r_state == RSP_D);
    w_sel_req   = w_own_i ? ibus.avalon_req : dbus.avalon_req;
    w_owner_act = w_own_i ? w_i_act : w_d_act;
  end

  // Command forwarding; read+write together is demoted to a plain write.
  always_comb begin
    w_mem_req = '0;
    if (!rst && w_cmd_phase) begin
      w_mem_req.write                      = w_sel_req.write;
      w_mem_req.read                       = w_sel_req.read & ~w_sel_req.write;
      w_mem_req.address[ADDR_W-1:0]        = w_sel_req.address[ADDR_W-1:0];
      w_mem_req.writedata[DATA_W-1:0]      = w_sel_req.writedata[DATA_W-1:0];
      w_mem_req.byteenable[DATA_W/8-1:0]   = w_sel_req.byteenable[DATA_W/8-1:0];
    end
  end

  always_comb begin
    w_iresp = '{readdata: '0, waitrequest: 1'b1, readdatavalid: 1'b0};
    w_dresp = '{readdata: '0, waitrequest: 1'b1, readdatavalid: 1'b0};
    if (!rst) begin
      if (w_cmd_phase && w_own_i)  w_iresp.waitrequest = mem.avalon_resp.waitrequest;
      if (w_cmd_phase && !w_own_i) w_dresp.waitrequest = mem.avalon_resp.waitrequest;
      if (w_rsp_phase && mem.avalon_resp.readdatavalid) begin
        if (w_own_i) begin
          w_iresp.readdatavalid        = 1'b1;
          w_iresp.readdata[DATA_W-1:0] = mem.avalon_resp.readdata[DATA_W-1:0];
        end else begin
          w_dresp.readdatavalid        = 1'b1;
          w_dresp.readdata[DATA_W-1:0] = mem.avalon_resp.readdata[DATA_W-1:0];
        end
      end
    end
  end

  assign mem.avalon_req   = w_mem_req;
  assign ibus.avalon_resp = w_iresp;
  assign dbus.avalon_resp = w_dresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_rr_ptr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i || w_grant_d) begin
            if (!mem.avalon_resp.waitrequest) begin
              if (w_sel_req.write)  r_state <= IDLE;
              else if (w_grant_i)   r_state <= RSP_I;
              else                  r_state <= RSP_D;
            end else begin
              r_state <= w_grant_i ? CMD_I : CMD_D;
            end
          end
          if (w_grant_i) begin
            r_starve_cnt <= '0;
          end else if (w_grant_d && w_i_act && (r_starve_cnt != c_max_wait)) begin
            r_starve_cnt <= r_starve_cnt + ARB_CNT_W'(1);
          end
          if (w_i_act && w_d_act) begin
            r_rr_ptr <= ~r_rr_ptr;
          end
        end
        CMD_I, CMD_D: begin
          // An owner that withdraws before acceptance is a pipeline flush.
          if (!w_owner_act) begin
            r_state <= IDLE;
          end else if (!mem.avalon_resp.waitrequest) begin
            if (w_sel_req.write)       r_state <= IDLE;
            else if (r_state == CMD_I) r_state <= RSP_I;
            else                       r_state <= RSP_D;
          end
        end
        RSP_I, RSP_D: begin
          if (mem.avalon_resp.readdatavalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_ibus_no_rw: assert property (@(posedge clk) disable iff (rst)
    !(ibus.avalon_req.read && ibus.avalon_req.write));
  a_dbus_no_rw: assert property (@(posedge clk) disable iff (rst)
    !(dbus.avalon_req.read && dbus.avalon_req.write));

endmodule
`default_nettype wire

// File: doc/ibus_dbus_arbiter.md
Name: ibus_dbus_arbiter

Overview:
- Shares one Avalon-MM memory port between two masters: the IF instruction fetch bus (ibus) and the MEM data bus (dbus).
- Sits between the core and a single-port unified memory or bus fabric.
- Serialises accesses and routes read responses back to the owning master.
- Enforces at most one outstanding transaction, with an anti-starvation counter for ibus.

Parameters:
- ADDR_W, 32, address width of avalon_req_t.address.
- DATA_W, 32, data width of writedata and readdata.
- ROUND_ROBIN, 0, 0 = dbus fixed priority with starvation guard; 1 = alternate winner on contention.
- MAX_WAIT, 4, consecutive ibus contention losses before ibus is forced to win (used only when ROUND_ROBIN = 0; range 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ibus_avalon_req  in  avalon_req_t  fetch request from IF
- ibus_avalon_resp  out  avalon_resp_t  response to IF
- dbus_avalon_req  in  avalon_req_t  load/store request from MEM
- dbus_avalon_resp  out  avalon_resp_t  response to MEM
- mem_avalon_req  out  avalon_req_t  request to shared memory
- mem_avalon_resp  in  avalon_resp_t  response from shared memory

Struct fields:
- avalon_req_t: read, write, address[ADDR_W], writedata[DATA_W], byteenable[DATA_W/8].
- avalon_resp_t: readdata[DATA_W], waitrequest, readdatavalid.

Behaviour:
- Clocking and reset are fixed: one clock, clk; reset is asynchronous and active-high, rst.
- Reset state: FSM = IDLE, starvation counter = 0, round-robin pointer = dbus.
- Outputs while rst is high: mem_avalon_req all zero; both resp outputs have waitrequest=1, readdatavalid=0, readdata=0.
- FSM states:
  - IDLE: no owner.
  - CMD_I / CMD_D: owner's command presented, waiting for waitrequest low.
  - RSP_I / RSP_D: read accepted, waiting for readdatavalid.
- Grant is combinational in IDLE (zero added latency). A single requester is forwarded to mem_avalon_req in the same cycle.
- Grant from IDLE:
  - If waitrequest is low that cycle: a write completes and the FSM stays IDLE; a read goes to RSP_x.
  - Otherwise the FSM enters CMD_x.
- CMD_x:
  - Owner's req is forwarded; owner's waitrequest mirrors mem waitrequest.
  - On waitrequest low: read -> RSP_x; write -> IDLE.
  - Owner drops read and write before acceptance (pipeline flush): -> IDLE, nothing issued.
- RSP_x:
  - mem_avalon_req forced to zero; both masters see waitrequest=1.
  - On readdatavalid: readdata and readdatavalid=1 go to the owner only; next state IDLE.
  - The response is delivered even if the owner has since dropped its request; IF discards stale data itself.
- Non-owner always sees waitrequest=1 and readdatavalid=0. The non-owner's readdata is don't-care; drive 0.
- Contention (both request in IDLE):
  - ROUND_ROBIN=0: dbus wins unless starvation counter == MAX_WAIT, then ibus wins.
  - ROUND_ROBIN=1: the pointer's master wins; the pointer flips to the other master after each grant under contention.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) on each IDLE-cycle grant to dbus while ibus is requesting.
  - Clears on any ibus grant.
  - Holds otherwise.
- A write with read=write=1 is illegal: assertion fires; treat it as a write.
- No bubble between back-to-back transactions: a return to IDLE in cycle N allows a new grant in cycle N+1.

Decomposition:
- avalon_req_t and avalon_resp_t stay in the shared core package (core.svh).
- Add to the package: enum arb_state_e {IDLE, CMD_I, CMD_D, RSP_I, RSP_D} and localparam ARB_CNT_W = 4.
- No sub-module: FSM, counter and muxing fit in one module of roughly 180 lines.

Test Plan:
- ibus read 0x100 alone, memory waitrequest=0, readdatavalid 1 cycle later with 0xDEADBEEF:
  - mem req appears in the same cycle;
  - ibus gets readdatavalid=1 with 0xDEADBEEF on cycle 2;
  - dbus sees waitrequest=1 throughout.
- ibus read and dbus write 0x200/0x55 in the same cycle, ROUND_ROBIN=0:
  - dbus write issued first;
  - ibus read issued on the next cycle;
  - ibus counter goes 0 -> 1 -> 0.
- dbus requests every cycle with ibus requesting, MAX_WAIT=4:
  - ibus is granted after exactly 4 dbus grants;
  - the counter clears.
- ibus read granted with waitrequest held high 3 cycles, then ibus drops read (flush):
  - FSM returns to IDLE;
  - no readdatavalid is delivered;
  - a dbus request is granted the next cycle.
- ibus read accepted, ibus then drops req, readdatavalid arrives 2 cycles later:
  - data is routed to ibus only;
  - a dbus read waiting meanwhile is issued the cycle after.
- rst asserted asynchronously while in RSP_D:
  - all outputs reach reset values before the next clk edge;
  - FSM = IDLE after rst deasserts.
